// File: rtl/zwait_sched.sv
// zwait_sched: Z80 wait-source sequencer.
// Synchronises per-source wait flags into fclk, grants one source at a time
// (round-robin), handshakes with the service agent, and issues a single
// registered wait_end pulse per service. A saturating counter bounds the time
// spent in GRANT+SERVE and, separately, in DRAIN so the Z80 can never hang.
module zwait_sched #(
    parameter int                 NSRC    = 7,
    parameter int                 TMO_W   = 16,
    parameter logic [TMO_W-1:0]   TMO_MAX = 16'hFFFF
) (
    input  logic            fclk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] waits_in,
    input  logic            svc_ack,
    input  logic            svc_done,
    input  logic            err_clr,
    output logic            grant_vld,
    output logic [2:0]      grant_id,
    output logic            wait_end,
    output logic            busy,
    output logic            tmo_err,
    output logic [NSRC-1:0] dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SERVE,
        S_RELEASE,
        S_DRAIN
    } state_t;

    // Counter value seen in the last allowed cycle; the transition taken in
    // that cycle lands exactly TMO_MAX cycles after entering the state group.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;
    localparam logic [2:0]       LAST_ID  = 3'(NSRC - 1);

    state_t             r_state, w_nxt;
    logic [NSRC-1:0]    r_meta, r_ws;
    logic [2:0]         r_gid, r_rr_ptr, w_pick, w_idx;
    logic               w_found;
    logic [TMO_W-1:0]   r_cnt;
    logic               w_hit, w_tmo_set, w_latch;
    logic               r_wait_end, r_tmo_err;
    logic [NSRC-1:0]    r_dropped, w_gmask, w_drop_set;

    // Two-flop synchroniser; the FSM only ever looks at r_ws.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_ws   <= '0;
        end else begin
            r_meta <= waits_in;
            r_ws   <= r_meta;
        end
    end

    // Round-robin pick: first set bit of r_ws scanning up from r_rr_ptr, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(r_rr_ptr) + i >= NSRC)
                w_idx = 3'(int'(r_rr_ptr) + i - NSRC);
            else
                w_idx = 3'(int'(r_rr_ptr) + i);
            if (!w_found && r_ws[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_hit = (r_cnt >= TMO_LAST);

    // FSM state register.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Next-state logic. In GRANT, done/timeout release outranks a vanished
    // source, which in turn outranks an ack.
    always_comb begin
        w_nxt     = r_state;
        w_tmo_set = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nxt   = S_GRANT;
                    w_latch = 1'b1;
                end
            end
            S_GRANT: begin
                w_tmo_set = w_hit;
                if (svc_done || w_hit)  w_nxt = S_RELEASE;
                else if (!r_ws[r_gid])  w_nxt = S_IDLE;
                else if (svc_ack)       w_nxt = S_SERVE;
            end
            S_SERVE: begin
                w_tmo_set = w_hit;
                if (svc_done || w_hit)  w_nxt = S_RELEASE;
            end
            S_RELEASE: w_nxt = S_DRAIN;
            S_DRAIN: begin
                if (r_ws == '0) begin
                    w_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_nxt     = S_IDLE;
                    w_tmo_set = 1'b1;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Timeout counter: zeroed in IDLE/RELEASE, counts elsewhere, saturates.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == S_IDLE || r_state == S_RELEASE)
            r_cnt <= '0;
        else if (r_cnt != TMO_MAX)
            r_cnt <= r_cnt + 1'b1;
    end

    // Grant index latched on grant; round-robin pointer advances on release only.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_gid    <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_latch)
                r_gid <= w_pick;
            if (r_state == S_RELEASE)
                r_rr_ptr <= (r_gid == LAST_ID) ? 3'd0 : r_gid + 3'd1;
        end
    end

    // Sources still pending at release, other than the one just serviced.
    always_comb begin
        w_gmask        = '0;
        w_gmask[r_gid] = 1'b1;
        w_drop_set     = (r_state == S_RELEASE) ? (r_ws & ~w_gmask) : '0;
    end

    // Sticky status and registered release pulse; a same-cycle set beats err_clr.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_end <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_dropped  <= '0;
        end else begin
            r_wait_end <= (w_nxt == S_RELEASE);
            r_tmo_err  <= w_tmo_set | (r_tmo_err & ~err_clr);
            r_dropped  <= (err_clr ? '0 : r_dropped) | w_drop_set;
        end
    end

    assign grant_vld = (r_state == S_GRANT) || (r_state == S_SERVE);
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_gid;
    assign wait_end  = r_wait_end;
    assign tmo_err   = r_tmo_err;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_zwait_sched.sv
// Directed bench for zwait_sched (NSRC=7, TMO_MAX=16 so the timeout is reachable).
module tb_zwait_sched;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] waits_in = '0;
    logic       svc_ack = 1'b0, svc_done = 1'b0, err_clr = 1'b0;
    logic       grant_vld, wait_end, busy, tmo_err;
    logic [2:0] grant_id;
    logic [6:0] dropped;

    int   checks = 0, errors = 0, we_pulses = 0;
    logic we_prev = 1'b0;

    zwait_sched #(.NSRC(7), .TMO_W(16), .TMO_MAX(16'd16)) dut (
        .fclk(fclk), .rst_n(rst_n), .waits_in(waits_in),
        .svc_ack(svc_ack), .svc_done(svc_done), .err_clr(err_clr),
        .grant_vld(grant_vld), .grant_id(grant_id), .wait_end(wait_end),
        .busy(busy), .tmo_err(tmo_err), .dropped(dropped)
    );

    always #5 fclk = ~fclk;

    // Count release pulses and flag any two in consecutive cycles.
    always @(negedge fclk) begin
        if (wait_end === 1'b1) begin
            we_pulses++;
            checks++;
            if (we_prev) begin
                errors++;
                $display("FAIL wait_end_consecutive got=1 exp=0");
            end
        end
        we_prev = (wait_end === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; waits_in = '0; svc_ack = 0; svc_done = 0; err_clr = 0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy !== 1'b0; i++) step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({grant_vld, grant_id, wait_end, busy, tmo_err, dropped} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outs got=%0h exp=0",
                     {grant_vld, grant_id, wait_end, busy, tmo_err, dropped});
        end
        rst_n = 1'b1;
        step(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_single();
        int p0;
        p0 = we_pulses;
        waits_in = 7'b0000001;
        step(3);
        checks++;
        if ({grant_vld, grant_id} !== 4'b1_000) begin
            errors++; $display("FAIL t1_grant got=%0h exp=8", {grant_vld, grant_id});
        end
        step(1); svc_ack = 1; step(1); svc_ack = 0;
        checks++;
        if (grant_vld !== 1'b1) begin errors++; $display("FAIL t1_serve got=%0b exp=1", grant_vld); end
        step(3); svc_done = 1; step(1); svc_done = 0;
        checks++;
        if (wait_end !== 1'b1) begin errors++; $display("FAIL t1_wait_end got=%0b exp=1", wait_end); end
        waits_in = '0;
        step(1);
        checks++;
        if ({wait_end, busy} !== 2'b01) begin
            errors++; $display("FAIL t1_drain got=%0b exp=01", {wait_end, busy});
        end
        wait_idle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle got=%0b exp=0", busy); end
        checks++;
        if (we_pulses - p0 !== 1) begin errors++; $display("FAIL t1_pulses got=%0d exp=1", we_pulses - p0); end
        checks++;
        if (tmo_err !== 1'b0) begin errors++; $display("FAIL t1_tmo got=%0b exp=0", tmo_err); end
    endtask

    task automatic test_round_robin();
        do_reset();
        waits_in = 7'b0000011;
        step(3);
        checks++;
        if ({grant_vld, grant_id} !== 4'b1_000) begin
            errors++; $display("FAIL t2_grant0 got=%0h exp=8", {grant_vld, grant_id});
        end
        svc_done = 1; step(1); svc_done = 0;
        checks++;
        if (wait_end !== 1'b1) begin errors++; $display("FAIL t2_we0 got=%0b exp=1", wait_end); end
        waits_in = '0;
        wait_idle();
        checks++;
        if (dropped !== 7'b0000010) begin errors++; $display("FAIL t2_dropped got=%0h exp=2", dropped); end
        waits_in = 7'b0000011;
        step(3);
        checks++;
        if ({grant_vld, grant_id} !== 4'b1_001) begin
            errors++; $display("FAIL t2_grant1 got=%0h exp=9", {grant_vld, grant_id});
        end
        svc_done = 1; step(1); svc_done = 0;
        waits_in = '0;
        wait_idle();
        checks++;
        if (dropped !== 7'b0000011) begin errors++; $display("FAIL t2_dropped2 got=%0h exp=3", dropped); end
        err_clr = 1; step(1); err_clr = 0;
        checks++;
        if (dropped !== 7'b0) begin errors++; $display("FAIL t2_clr got=%0h exp=0", dropped); end
    endtask

    task automatic test_timeout();
        do_reset();
        waits_in = 7'b0000010;
        step(3);
        checks++;
        if ({grant_vld, grant_id} !== 4'b1_001) begin
            errors++; $display("FAIL t3_grant got=%0h exp=9", {grant_vld, grant_id});
        end
        step(15);
        checks++;
        if ({wait_end, grant_vld} !== 2'b01) begin
            errors++; $display("FAIL t3_pre got=%0b exp=01", {wait_end, grant_vld});
        end
        step(1);
        checks++;
        if ({wait_end, tmo_err} !== 2'b11) begin
            errors++; $display("FAIL t3_release got=%0b exp=11", {wait_end, tmo_err});
        end
        waits_in = '0;
        wait_idle();
        checks++;
        if ({busy, tmo_err} !== 2'b01) begin
            errors++; $display("FAIL t3_sticky got=%0b exp=01", {busy, tmo_err});
        end
        err_clr = 1; step(1); err_clr = 0;
        checks++;
        if (tmo_err !== 1'b0) begin errors++; $display("FAIL t3_clr got=%0b exp=0", tmo_err); end
    endtask

    task automatic test_vanish();
        int p0;
        p0 = we_pulses;
        waits_in = 7'b0000001;
        step(3);
        checks++;
        if (grant_vld !== 1'b1) begin errors++; $display("FAIL t4_grant got=%0b exp=1", grant_vld); end
        waits_in = '0;
        step(3);
        checks++;
        if ({grant_vld, busy} !== 2'b00) begin
            errors++; $display("FAIL t4_idle got=%0b exp=00", {grant_vld, busy});
        end
        checks++;
        if (we_pulses !== p0) begin errors++; $display("FAIL t4_no_we got=%0d exp=%0d", we_pulses, p0); end
    endtask

    task automatic test_async_reset();
        int p0;
        waits_in = 7'b0000001;
        step(3);
        svc_ack = 1; step(1); svc_ack = 0;
        checks++;
        if (grant_vld !== 1'b1) begin errors++; $display("FAIL t5_serve got=%0b exp=1", grant_vld); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_vld, busy, wait_end} !== 3'b000) begin
            errors++; $display("FAIL t5_async got=%0b exp=000", {grant_vld, busy, wait_end});
        end
        waits_in = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        p0 = we_pulses;
        waits_in = 7'b0000100;
        step(3);
        checks++;
        if ({grant_vld, grant_id} !== 4'b1_010) begin
            errors++; $display("FAIL t5_regrant got=%0h exp=a", {grant_vld, grant_id});
        end
        svc_ack = 1; step(1); svc_ack = 0;
        step(1);
        svc_done = 1; step(1); svc_done = 0;
        waits_in = '0;
        wait_idle();
        checks++;
        if ({busy, we_pulses - p0} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL t5_done got=%0b/%0d exp=0/1", busy, we_pulses - p0);
        end
    endtask

    task automatic test_done_no_ack();
        int p0;
        p0 = we_pulses;
        waits_in = 7'b0000001;
        step(3);
        svc_done = 1; step(1); svc_done = 0;
        checks++;
        if ({wait_end, grant_vld} !== 2'b10) begin
            errors++; $display("FAIL t6_release got=%0b exp=10", {wait_end, grant_vld});
        end
        step(1);
        checks++;
        if (wait_end !== 1'b0) begin errors++; $display("FAIL t6_single got=%0b exp=0", wait_end); end
        waits_in = '0;
        wait_idle();
        checks++;
        if ({busy, we_pulses - p0} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL t6_pulses got=%0b/%0d exp=0/1", busy, we_pulses - p0);
        end
    endtask

    task automatic test_ignore_idle();
        int p0;
        p0 = we_pulses;
        svc_ack = 1; svc_done = 1; step(1); svc_ack = 0; svc_done = 0;
        step(1);
        checks++;
        if ({busy, wait_end, grant_vld} !== 3'b000 || we_pulses !== p0) begin
            errors++; $display("FAIL idle_pulses got=%0b exp=000", {busy, wait_end, grant_vld});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_vanish();
        test_async_reset();
        test_done_no_ack();
        test_ignore_idle();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
